// File: rtl/divu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : divu_unit
//  Description : Multi-cycle unsigned 32-bit divider (restoring algorithm,
//                one quotient bit per clock). Produces {remainder, quotient}
//                for the HiLo registers.
//  Ports       :
//    clk          in   1   single clock, rising edge
//    reset        in   1   synchronous active-high reset
//    dataA        in  32   dividend (unsigned)
//    dataB        in  32   divisor (unsigned)
//    Signal       in   6   ALU control funct code; only DIVU starts a divide
//    dataOut      out 64   [63:32] remainder (Hi), [31:0] quotient (Lo)
//    busy         out  1   high while iterating
//    done         out  1   one-cycle pulse when dataOut holds a new result
//    div_by_zero  out  1   one-cycle pulse with done when divisor was zero
//  Revision    : 1.0  initial release
// ============================================================================
module divu_unit #(
    parameter logic [5:0] DIVU = 6'b011011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [63:0] dataOut,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [5:0]  cnt_q,     cnt_d;
    logic [31:0] rem_q,     rem_d;      // partial remainder, always < divisor
    logic [31:0] quot_q,    quot_d;     // dividend bits shift out, quotient bits shift in
    logic [31:0] divisor_q, divisor_d;
    logic [63:0] result_q,  result_d;   // only written on completion
    logic        dbz_q,     dbz_d;

    // Shifted remainder needs 33 bits: it can reach 2*divisor-1.
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;

    assign w_rem_shift = {rem_q, quot_q[31]};
    // A negative trial difference wraps to a value with bit 32 set; a
    // non-negative one is below the divisor and so has bit 32 clear.
    assign w_diff      = w_rem_shift - {1'b0, divisor_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (Signal == DIVU) begin
                    quot_d    = dataA;
                    divisor_d = dataB;
                    rem_d     = 32'd0;
                    cnt_d     = 6'd32;
                    if (dataB == 32'd0) begin
                        state_d  = S_DONE;
                        result_d = {dataA, 32'hFFFF_FFFF};
                        dbz_d    = 1'b1;
                    end else begin
                        state_d  = S_BUSY;
                        dbz_d    = 1'b0;
                    end
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (!w_diff[32]) begin
                    rem_d  = w_diff[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = w_rem_shift[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                // Last step: publish the finished result on the same edge.
                if (cnt_q == 6'd1) begin
                    state_d  = S_DONE;
                    result_d = {rem_d, quot_d};
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            divisor_q <= 32'd0;
            result_q  <= 64'd0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign dataOut     = result_q;
    assign busy        = (state_q == S_BUSY);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = (state_q == S_DONE) && dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_divu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divu_unit
//  Description : Self-checking bench for divu_unit (directed + random vectors)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divu_unit;

    localparam logic [5:0] C_DIVU  = 6'b011011;
    localparam logic [5:0] C_OTHER = 6'b011010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    divu_unit #(.DIVU(C_DIVU)) dut (
        .clk         (clk),
        .reset       (reset),
        .dataA       (dataA),
        .dataB       (dataB),
        .Signal      (Signal),
        .dataOut     (dataOut),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Present a one-cycle DIVU; returns at the negedge inside cycle 1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = C_DIVU;
        @(negedge clk);
        Signal = 6'd0;
    endtask

    // From cycle 1, find the cycle in which done is seen; -1 if never.
    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        Signal = C_DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dataOut !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dataOut=%h busy=%b done=%b dbz=%b, want 0/0/0/0",
                     dataOut, busy, done, div_by_zero);
        end
        reset  = 1'b0;
        Signal = 6'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_priority: busy=%b done=%b, want 0/0", busy, done);
            end
        end
    endtask

    task automatic test_basic;
        start_op(32'd100, 32'd7);
        for (int c = 1; c <= 33; c++) begin
            checks++;
            if (busy !== 1'(c <= 32)) begin
                errors++;
                $display("FAIL basic_busy cycle %0d: busy=%b want %b", c, busy, 1'(c <= 32));
            end
            checks++;
            if (done !== 1'(c == 33)) begin
                errors++;
                $display("FAIL basic_done cycle %0d: done=%b want %b", c, done, 1'(c == 33));
            end
            if (c <= 32) begin
                checks++;
                if (dataOut !== 64'd0) begin
                    errors++;
                    $display("FAIL basic_hold cycle %0d: dataOut=%h want 0", c, dataOut);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (dataOut !== {32'd2, 32'd14} || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: dataOut=%h dbz=%b want %h/0",
                     dataOut, div_by_zero, {32'd2, 32'd14});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataOut !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL basic_after: busy=%b done=%b dataOut=%h", busy, done, dataOut);
        end
    endtask

    task automatic test_edges;
        int cyc;
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(40, cyc);
        checks++;
        if (cyc !== 33 || dataOut !== {32'h0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL edge_div1: cycle=%0d dataOut=%h want 33/%h",
                     cyc, dataOut, {32'h0, 32'hFFFF_FFFF});
        end
        @(negedge clk);
        start_op(32'd3, 32'd10);
        wait_done(40, cyc);
        checks++;
        if (cyc !== 33 || dataOut !== {32'd3, 32'h0}) begin
            errors++;
            $display("FAIL edge_small: cycle=%0d dataOut=%h want 33/%h",
                     cyc, dataOut, {32'd3, 32'h0});
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        start_op(32'd5, 32'd0);
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b1 || busy !== 1'b0 ||
            dataOut !== {32'd5, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL dbz_cycle1: done=%b dbz=%b busy=%b dataOut=%h want 1/1/0/%h",
                     done, div_by_zero, busy, dataOut, {32'd5, 32'hFFFF_FFFF});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0 ||
            dataOut !== {32'd5, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL dbz_after: done=%b dbz=%b busy=%b dataOut=%h",
                     done, div_by_zero, busy, dataOut);
        end
    endtask

    task automatic test_reset_abort;
        int ndone;
        int cyc;
        start_op(32'd100, 32'd7);
        for (int c = 1; c < 10; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dataOut !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: dataOut=%h busy=%b done=%b want 0/0/0",
                     dataOut, busy, done);
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles after abort, want 0", ndone);
        end
        start_op(32'd9, 32'd2);
        wait_done(40, cyc);
        checks++;
        if (cyc !== 33 || dataOut !== {32'd1, 32'd4}) begin
            errors++;
            $display("FAIL abort_restart: cycle=%0d dataOut=%h want 33/%h",
                     cyc, dataOut, {32'd1, 32'd4});
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        int ndone;
        int first;
        start_op(32'd100, 32'd7);
        for (int c = 1; c < 5; c++) @(negedge clk);
        Signal = C_DIVU;
        dataA  = 32'd50;
        dataB  = 32'd5;
        @(negedge clk);
        Signal = 6'd0;
        ndone  = 0;
        first  = -1;
        for (int c = 6; c <= 45; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
                checks++;
                if (dataOut !== {32'd2, 32'd14}) begin
                    errors++;
                    $display("FAIL ignore_result: dataOut=%h want %h", dataOut, {32'd2, 32'd14});
                end
            end
            dataA = $urandom;
            dataB = $urandom;
            @(negedge clk);
        end
        checks++;
        if (ndone != 1 || first != 33) begin
            errors++;
            $display("FAIL ignore_done: pulses=%0d first=%0d want 1/33", ndone, first);
        end
    endtask

    task automatic test_done_ignore;
        int cyc;
        start_op(32'd20, 32'd3);
        wait_done(40, cyc);
        Signal = C_DIVU;
        dataA  = 32'd77;
        dataB  = 32'd1;
        @(negedge clk);
        Signal = 6'd0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || dataOut !== {32'd2, 32'd6}) begin
                errors++;
                $display("FAIL done_ignore: busy=%b done=%b dataOut=%h want 0/0/%h",
                         busy, done, dataOut, {32'd2, 32'd6});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_other_signal;
        Signal = C_OTHER;
        dataA  = 32'd40;
        dataB  = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || dataOut !== {32'd2, 32'd6}) begin
                errors++;
                $display("FAIL other_signal: busy=%b done=%b dataOut=%h", busy, done, dataOut);
            end
        end
        Signal = 6'd0;
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          exp_cyc;
        int          cyc;
        logic        dbz_seen;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 10)
                0:       b = 32'd0;
                5:       b = a;
                7:       b = 32'($urandom_range(1, 255));
                3:       b = a >> ($urandom_range(0, 31));
                default: b = $urandom;
            endcase
            if (b == 32'd0) begin
                exp     = {a, 32'hFFFF_FFFF};
                exp_cyc = 1;
            end else begin
                exp     = {a % b, a / b};
                exp_cyc = 33;
            end
            start_op(a, b);
            wait_done(40, cyc);
            dbz_seen = div_by_zero;
            checks++;
            if (cyc != exp_cyc || dataOut !== exp || dbz_seen !== (b == 32'd0)) begin
                errors++;
                $display("FAIL random %0d: a=%h b=%h cycle=%0d dataOut=%h dbz=%b want %0d/%h/%b",
                         i, a, b, cyc, dataOut, dbz_seen, exp_cyc, exp, (b == 32'd0));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = 6'd0;
        test_reset;
        test_basic;
        test_edges;
        test_div_zero;
        test_reset_abort;
        test_busy_ignore;
        test_done_ignore;
        test_other_signal;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divu_unit.md
DIVU_UNIT -- requirements
Module: divu_unit

Interface
REQ-001 SHALL have parameter DIVU, default 6'b011011, funct code that starts an unsigned divide.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port dataA  input  32  dividend, unsigned.
REQ-005 SHALL have port dataB  input  32  divisor, unsigned.
REQ-006 SHALL have port Signal  input  6  operation code from the ALU control; only DIVU acts.
REQ-007 SHALL have port dataOut  output  64  result for the HiLo registers: [63:32] remainder (Hi), [31:0] quotient (Lo).
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when dataOut holds a new result.
REQ-010 SHALL have port div_by_zero  output  1  one-cycle pulse, coincident with done, when the divisor was zero.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-012 SHALL start in IDLE when Signal==DIVU at a clock edge (start cycle 0): register dataA, dataB, clear partial remainder, load iteration counter with 32.
REQ-013 SHALL, on a nonzero divisor, go IDLE->BUSY and perform one restoring-division step per cycle: shift {remainder, quotient} left by one, subtract divisor from the 33-bit remainder, keep the difference and set quotient LSB 1 if non-negative, otherwise restore and set LSB 0.
REQ-014 SHALL decrement the counter each BUSY cycle and go BUSY->DONE after exactly 32 steps; dataOut updates on that edge, and done is high during cycle 33 relative to the start edge.
REQ-015 SHALL go DONE->IDLE after one cycle; a DIVU in the DONE cycle is ignored.
REQ-016 SHALL hold busy high in BUSY only; done high in DONE only.
REQ-017 SHALL, on a zero divisor, go IDLE->DONE directly and set dataOut={dataA, 32'hFFFFFFFF}; done and div_by_zero high in cycle 1.
REQ-018 SHALL ignore Signal==DIVU in BUSY; operand registers and the counter stay unchanged.
REQ-019 SHALL ignore every Signal value other than DIVU in all states.
REQ-020 SHALL hold dataOut stable from one completion until the next completion or reset; intermediate partial values never appear on dataOut.
REQ-021 SHALL produce quotient = floor(dataA/dataB) and remainder = dataA mod dataB over the full unsigned 32-bit range, including dataA < dataB (quotient 0) and dataB==1.
REQ-022 SHALL not depend on dataA/dataB after the start edge; they may change freely during BUSY.

Reset
REQ-023 SHALL, when reset is high at a clock edge, force state IDLE, dataOut=64'h0, busy=0, done=0, div_by_zero=0, and clear the counter and operand registers.
REQ-024 SHALL give reset priority over a simultaneous DIVU start; no division starts on that edge.
REQ-025 SHALL abort a division when reset is asserted in BUSY; no done pulse follows.

Verification
REQ-026 SHALL be verified: dataA=100, dataB=7, DIVU for one cycle -> busy cycles 1-32, done in cycle 33, dataOut={32'd2, 32'd14}.
REQ-027 SHALL be verified: dataA=32'hFFFFFFFF, dataB=1 -> dataOut={32'h0, 32'hFFFFFFFF}; dataA=3, dataB=10 -> dataOut={32'd3, 32'h0}.
REQ-028 SHALL be verified: dataA=5, dataB=0 -> done and div_by_zero in cycle 1, busy never high, dataOut={32'd5, 32'hFFFFFFFF}.
REQ-029 SHALL be verified: start 100/7, reset at cycle 10 -> dataOut=0 and busy=0 after that edge, no done; a new 9/2 then gives {32'd1, 32'd4}.
REQ-030 SHALL be verified: start 100/7, second DIVU with 50/5 at cycle 5 and changed operands during BUSY -> single done at cycle 33 with {32'd2, 32'd14}.
REQ-031 SHALL be verified against a reference model on at least 1000 random operand pairs, including dataB=0 and dataA=dataB, with zero mismatches.
